// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a single uart_tx byte port.
// A grant is held until the last byte or MAX_BEATS handshakes, whichever comes first.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, rr_n, grant_n, pick, g_next;
    logic [BW-1:0] beat_cnt, cnt_n;
    logic [IW:0]   idx;
    logic          any_req, g_valid, g_last, hs, done;

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick    = rr_ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NUM_REQ))
                idx = idx - (IW+1)'(NUM_REQ);
            if (!any_req && req_valid[idx[IW-1:0]]) begin
                any_req = 1'b1;
                pick    = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        tx_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                tx_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign g_next = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    always_comb begin
        state_n   = state;
        grant_n   = grant_id;
        rr_n      = rr_ptr;
        cnt_n     = beat_cnt;
        busy      = (state == BUSY);
        tx_valid  = 1'b0;
        req_ready = '0;
        hs        = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant_n = pick;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                tx_valid = g_valid;
                for (int i = 0; i < NUM_REQ; i++)
                    req_ready[i] = (grant_id == IW'(i)) && tx_ready;
                hs   = g_valid && tx_ready;
                done = hs && (g_last || (beat_cnt + BW'(1) == BW'(MAX_BEATS)));
                if (hs)
                    cnt_n = beat_cnt + BW'(1);
                if (done) begin
                    state_n = IDLE;
                    rr_n    = g_next;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            rr_ptr   <= rr_n;
            beat_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte sources per requester, a handshake
// log with cycle stamps, and hand-computed expected grant/byte sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic [1:0]  grant_id;

    uart_tx_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BEATS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] mem [4][8];
    int         len [4];
    int         pos [4];
    logic [3:0] stall;

    int cyc = 0;
    int log_gid [64];
    int log_data [64];
    int log_cyc [64];
    int nlog = 0;

    int stab_viol = 0;
    int excl_viol = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    bit          pat_on = 1'b0;
    int          pat_base = 0;
    logic [31:0] rdy_pat;
    logic [31:0] stl_pat;

    task automatic check(string tag, int got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        int k;
        stall = '0;
        if (pat_on) begin
            k = cyc - pat_base;
            if (k >= 0 && k < 32) begin
                tx_ready = rdy_pat[k];
                stall[2] = stl_pat[k];
            end else begin
                tx_ready = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pos[i] < len[i] && !stall[i]) begin
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = mem[i][pos[i]][7:0];
                req_last[i]         = mem[i][pos[i]][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[i*8 +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic load(int i, logic [7:0] first, int n);
        for (int b = 0; b < n; b++)
            mem[i][b] = {(b == n - 1), first + 8'(b)};
        len[i] = n;
        pos[i] = 0;
    endtask

    task automatic tick();
        logic [3:0] pop;
        logic [3:0] others;
        @(negedge clk);
        pop = req_valid & req_ready;
        if (tx_valid && tx_ready) begin
            log_gid[nlog]  = int'(grant_id);
            log_data[nlog] = int'(tx_data);
            log_cyc[nlog]  = cyc;
            nlog++;
        end
        if (prev_hold && tx_valid && tx_data !== prev_data)
            stab_viol++;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        others = req_ready & ~(4'b0001 << grant_id);
        if (others != 4'b0000 || (!busy && req_ready != 4'b0000))
            excl_viol++;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++)
            if (pop[i]) pos[i]++;
        drive();
    endtask

    task automatic run_until(string tag, int n);
        int b = 0;
        while (nlog < n && b < 40) begin
            tick();
            b++;
        end
        check({tag, "_count"}, nlog, n);
        tick();
        tick();
    endtask

    task automatic check_log(string tag, int k, int gid, int data, int base, int dc);
        check($sformatf("%s_gid%0d", tag, k), log_gid[k], gid);
        check($sformatf("%s_data%0d", tag, k), log_data[k], data);
        if (dc >= 0)
            check($sformatf("%s_cyc%0d", tag, k), log_cyc[k] - base, dc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive();
    endtask

    int base;

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b1;
        stall    = '0;
        for (int i = 0; i < 4; i++) begin
            len[i] = 0;
            pos[i] = 0;
        end
        drive();
        do_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);

        // single packet from requester 2
        nlog = 0;
        base = cyc;
        load(2, 8'h41, 3);
        drive();
        #1;
        check("t1_idle_tx_valid", tx_valid, 0);
        tick();
        #1;
        check("t1_lat_tx_valid", tx_valid, 1);
        run_until("t1", 3);
        check_log("t1", 0, 2, 'h41, base, 1);
        check_log("t1", 1, 2, 'h42, base, 2);
        check_log("t1", 2, 2, 'h43, base, 3);
        check("t1_busy_after", log_cyc[2] - base, 3);
        #1;
        check("t1_grant_hold", grant_id, 2);
        check("t1_busy_end", busy, 0);

        // simultaneous requests 0,1,3 from reset
        do_reset();
        nlog = 0;
        base = cyc;
        load(0, 8'hA0, 2);
        load(1, 8'hB0, 2);
        load(3, 8'hC0, 2);
        drive();
        run_until("t2", 6);
        check_log("t2", 0, 0, 'hA0, base, 1);
        check_log("t2", 1, 0, 'hA1, base, 2);
        check_log("t2", 2, 1, 'hB0, base, 4);
        check_log("t2", 3, 1, 'hB1, base, 5);
        check_log("t2", 4, 3, 'hC0, base, 7);
        check_log("t2", 5, 3, 'hC1, base, 8);

        // wrap-around: requester 2 sets rr_ptr to 3, then 0 and 3 together
        nlog = 0;
        load(2, 8'h55, 1);
        drive();
        run_until("t3a", 1);
        nlog = 0;
        load(0, 8'h60, 1);
        load(3, 8'h70, 1);
        drive();
        run_until("t3", 2);
        check_log("t3", 0, 3, 'h70, 0, -1);
        check_log("t3", 1, 0, 'h60, 0, -1);

        // forced release after 4 beats
        nlog = 0;
        load(1, 8'h10, 6);
        load(2, 8'hAA, 1);
        drive();
        run_until("t4", 7);
        check_log("t4", 0, 1, 'h10, 0, -1);
        check_log("t4", 3, 1, 'h13, 0, -1);
        check_log("t4", 4, 2, 'hAA, 0, -1);
        check_log("t4", 5, 1, 'h14, 0, -1);
        check_log("t4", 6, 1, 'h15, 0, -1);

        // backpressure and stalled requester
        nlog = 0;
        stab_viol = 0;
        excl_viol = 0;
        base = cyc;
        pat_base = cyc;
        rdy_pat = ~32'h0000_000C;
        stl_pat = 32'h0000_00E0;
        pat_on = 1'b1;
        load(2, 8'h20, 4);
        load(0, 8'h30, 1);
        drive();
        tick();
        tick();
        #1;
        check("t5_bp_valid", tx_valid, 1);
        check("t5_bp_data", tx_data, 'h21);
        check("t5_bp_ready", req_ready, 0);
        repeat (4) tick();
        #1;
        check("t5_stall_busy", busy, 1);
        check("t5_stall_valid", tx_valid, 0);
        check("t5_stall_grant", grant_id, 2);
        check("t5_stall_ready", req_ready, 4'b0100);
        run_until("t5", 5);
        pat_on = 1'b0;
        tx_ready = 1'b1;
        check_log("t5", 0, 2, 'h20, base, 1);
        check_log("t5", 1, 2, 'h21, base, 4);
        check_log("t5", 2, 2, 'h22, base, 8);
        check_log("t5", 3, 2, 'h23, base, 9);
        check_log("t5", 4, 0, 'h30, base, 11);
        check("t5_stable", stab_viol, 0);
        check("t5_exclusive", excl_viol, 0);

        // reset in the middle of a 5-byte packet from requester 3
        nlog = 0;
        load(3, 8'h50, 5);
        drive();
        repeat (3) tick();
        check("t6_pre_count", nlog, 2);
        rst = 1'b1;
        tx_ready = 1'b0;
        tick();
        rst = 1'b0;
        tx_ready = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_tx_valid", tx_valid, 0);
        check("t6_req_ready", req_ready, 0);
        check("t6_grant_id", grant_id, 0);
        nlog = 0;
        load(0, 8'h61, 1);
        load(3, 8'h50, 1);
        drive();
        run_until("t6", 2);
        check_log("t6", 0, 0, 'h61, 0, -1);
        check_log("t6", 1, 3, 'h50, 0, -1);
        check("t6_exclusive", excl_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
